// File: rtl/clock_pkg.sv
// Shared types and default timing constants for the digital-clock sequencer.
package clock_pkg;

  typedef enum logic [1:0] {
    RUN,
    SET_HOUR,
    SET_MIN
  } state_t;

  localparam int TICKS_PER_SEC_DEF   = 1000;
  localparam int DEBOUNCE_MS_DEF     = 20;
  localparam int REPEAT_DELAY_MS_DEF = 500;
  localparam int REPEAT_RATE_MS_DEF  = 200;
  localparam int BLINK_MS_DEF        = 250;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchronizer, stability counter and a registered
// one-cycle pulse on each accepted rising edge of the debounced level.
module btn_debounce #(
  parameter int DEBOUNCE_MS = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CW = (DEBOUNCE_MS > 1) ? $clog2(DEBOUNCE_MS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_MS - 1);

  logic          sync1;
  logic          sync2;
  logic          level_d;
  logic [CW-1:0] cnt;

  // NOTE: every register here is updated with <= so all flops sample the
  // values from before the edge, exactly as the hardware does.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      press   <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      level_d <= level;
      press   <= level & ~level_d;
      if (sync2 != level) begin
        if (cnt == CNT_LAST) begin
          level <= sync2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/clock_ctrl.sv
// Sequencing controller: 1 Hz divider, RUN-mode increment cascade, and the
// RUN / SET_HOUR / SET_MIN time-setting FSM with auto-repeat and blink.
module clock_ctrl
  import clock_pkg::*;
#(
  parameter int TICKS_PER_SEC   = TICKS_PER_SEC_DEF,
  parameter int DEBOUNCE_MS     = DEBOUNCE_MS_DEF,
  parameter int REPEAT_DELAY_MS = REPEAT_DELAY_MS_DEF,
  parameter int REPEAT_RATE_MS  = REPEAT_RATE_MS_DEF,
  parameter int BLINK_MS        = BLINK_MS_DEF
) (
  input  logic clkMSec,
  input  logic reset,
  input  logic modeBtn,
  input  logic incBtn,
  input  logic secMax,
  input  logic minMax,
  output logic secInc,
  output logic minInc,
  output logic hourInc,
  output logic secClr,
  output logic setHour,
  output logic setMin,
  output logic blink
);

  localparam int DIV_W   = $clog2(TICKS_PER_SEC);
  localparam int REP_W   = $clog2(REPEAT_DELAY_MS + 1);
  localparam int BLINK_W = $clog2(BLINK_MS);

  localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(TICKS_PER_SEC - 1);
  localparam logic [REP_W-1:0]   REP_FIRE   = REP_W'(REPEAT_DELAY_MS);
  localparam logic [REP_W-1:0]   REP_RELOAD = REP_W'(REPEAT_DELAY_MS - REPEAT_RATE_MS + 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_MS - 1);

  state_t             state;
  state_t             state_next;
  logic               state_change;
  logic               mode_level;
  logic               mode_press;
  logic               inc_level;
  logic               inc_press;
  logic               rep_pulse;
  logic [DIV_W-1:0]   div;
  logic [REP_W-1:0]   rep_cnt;
  logic [BLINK_W-1:0] blink_cnt;

  btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_mode_db (
    .clk   (clkMSec),
    .reset (reset),
    .raw   (modeBtn),
    .level (mode_level),
    .press (mode_press)
  );

  btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_inc_db (
    .clk   (clkMSec),
    .reset (reset),
    .raw   (incBtn),
    .level (inc_level),
    .press (inc_press)
  );

  // A mode press can only follow a cycle in which the level was accepted high.
  mode_press_has_level: assert property (
    @(posedge clkMSec) disable iff (reset) mode_press |-> $past(mode_level));

  always_ff @(posedge clkMSec) begin
    if (reset) state <= RUN;
    else       state <= state_next;
  end

  assign state_change = (state_next != state);
  assign rep_pulse    = (rep_cnt == REP_FIRE);

  // NOTE: every output and state_next gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_next = state;
    secInc     = 1'b0;
    minInc     = 1'b0;
    hourInc    = 1'b0;
    secClr     = 1'b0;
    setHour    = 1'b0;
    setMin     = 1'b0;
    if (!reset) begin
      unique case (state)
        RUN: begin
          secInc  = (div == DIV_LAST);
          minInc  = (div == DIV_LAST) & secMax;
          hourInc = (div == DIV_LAST) & secMax & minMax;
          if (mode_press) state_next = SET_HOUR;
        end
        SET_HOUR: begin
          setHour = 1'b1;
          if (mode_press) state_next = SET_MIN;
          else            hourInc    = inc_press | rep_pulse;
        end
        SET_MIN: begin
          setMin = 1'b1;
          if (mode_press) begin
            state_next = RUN;
            secClr     = 1'b1;
          end else begin
            minInc = inc_press | rep_pulse;
          end
        end
        default: state_next = RUN;
      endcase
    end
  end

  // Divider runs only in RUN and is parked at 0 while setting the time.
  always_ff @(posedge clkMSec) begin
    if (reset || state != RUN || mode_press || div == DIV_LAST) div <= '0;
    else                                                         div <= div + DIV_W'(1);
  end

  // Repeat counter counts cycles since the press; after the first repeat it is
  // reloaded so the next fire comes one repeat period later.
  always_ff @(posedge clkMSec) begin
    if (reset || state_change || !inc_level) begin
      rep_cnt <= '0;
    end else if (inc_press && state != RUN) begin
      rep_cnt <= REP_W'(1);
    end else if (rep_cnt == REP_FIRE) begin
      rep_cnt <= REP_RELOAD;
    end else if (rep_cnt != '0) begin
      rep_cnt <= rep_cnt + REP_W'(1);
    end
  end

  always_ff @(posedge clkMSec) begin
    if (reset || state_change || state == RUN) begin
      blink_cnt <= '0;
      blink     <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt <= '0;
      blink     <= ~blink;
    end else begin
      blink_cnt <= blink_cnt + BLINK_W'(1);
    end
  end

endmodule

// File: tb/tb_clock_ctrl.sv
// Directed bench for clock_ctrl: a per-cycle behavioural model plus literal
// timing expectations for each scenario.
module tb_clock_ctrl;

  logic clkMSec = 1'b0;
  logic reset   = 1'b1;
  logic modeBtn = 1'b0;
  logic incBtn  = 1'b0;
  logic secMax  = 1'b0;
  logic minMax  = 1'b0;
  logic secInc, minInc, hourInc, secClr, setHour, setMin, blink;

  clock_ctrl dut (
    .clkMSec (clkMSec),
    .reset   (reset),
    .modeBtn (modeBtn),
    .incBtn  (incBtn),
    .secMax  (secMax),
    .minMax  (minMax),
    .secInc  (secInc),
    .minInc  (minInc),
    .hourInc (hourInc),
    .secClr  (secClr),
    .setHour (setHour),
    .setMin  (setMin),
    .blink   (blink)
  );

  always #5 clkMSec = ~clkMSec;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  // Model state: mode 0=RUN 1=SET_HOUR 2=SET_MIN, age = cycles spent in mode.
  bit        m_valid = 1'b0;
  int        m_st, m_age, m_since;
  bit        m_armed;
  bit        m_mlvl, m_mlvl_p, m_mpress;
  bit        m_ilvl, m_ilvl_p, m_ipress;
  bit [21:0] m_mhist, m_ihist;

  int sec_q[$], min_q[$], hour_q[$], clr_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic int count_from(input int q[$], input int w);
    int n = 0;
    foreach (q[i]) if (q[i] >= w) n++;
    return n;
  endfunction

  function automatic int nth_from(input int q[$], input int w, input int n);
    int k = 0;
    foreach (q[i]) begin
      if (q[i] >= w) begin
        if (k == n) return q[i] - w;
        k++;
      end
    end
    return -1;
  endfunction

  // Compare the current cycle against the model, then advance the model
  // across the coming clock edge.
  task automatic model_cycle();
    logic [6:0] act_v, exp_v;
    bit tick, rep, incev, mode_p, inc_p;
    act_v = {secInc, minInc, hourInc, secClr, setHour, setMin, blink};
    if (secInc  === 1'b1) sec_q.push_back(cyc);
    if (minInc  === 1'b1) min_q.push_back(cyc);
    if (hourInc === 1'b1) hour_q.push_back(cyc);
    if (secClr  === 1'b1) clr_q.push_back(cyc);
    mode_p = m_mpress;
    inc_p  = m_ipress;
    if (m_valid && reset) begin
      check("events_in_reset", {28'd0, act_v[6:3]}, 32'd0);
    end else if (m_valid) begin
      tick  = (m_st == 0) && (m_age % 1000 == 999);
      rep   = m_armed && (m_since >= 500) && ((m_since - 500) % 200 == 0);
      incev = (inc_p || rep) && !mode_p && (m_st != 0);
      exp_v[6] = tick;
      exp_v[5] = (tick && secMax) || (m_st == 2 && incev);
      exp_v[4] = (tick && secMax && minMax) || (m_st == 1 && incev);
      exp_v[3] = mode_p && (m_st == 2);
      exp_v[2] = (m_st == 1);
      exp_v[1] = (m_st == 2);
      exp_v[0] = (m_st != 0) && ((m_age / 250) % 2 == 1);
      check("cycle_outputs", {25'd0, act_v}, {25'd0, exp_v});
    end

    if (reset) begin
      m_valid = 1'b1;
      m_st = 0; m_age = 0; m_since = 0; m_armed = 1'b0;
      m_mlvl = 1'b0; m_mlvl_p = 1'b0; m_mpress = 1'b0;
      m_ilvl = 1'b0; m_ilvl_p = 1'b0; m_ipress = 1'b0;
      m_mhist = '0; m_ihist = '0;
    end else if (m_valid) begin
      if (mode_p || !m_ilvl)          m_armed = 1'b0;
      else if (inc_p && m_st != 0) begin
        m_armed = 1'b1;
        m_since = 1;
      end else if (m_armed)           m_since++;
      if (mode_p) begin
        m_st  = (m_st + 1) % 3;
        m_age = 0;
      end else begin
        m_age++;
      end
      // A level is accepted once the 20 synchronized samples all disagree with it.
      m_mhist  = {m_mhist[20:0], modeBtn};
      m_ihist  = {m_ihist[20:0], incBtn};
      m_mpress = m_mlvl && !m_mlvl_p;
      m_ipress = m_ilvl && !m_ilvl_p;
      m_mlvl_p = m_mlvl;
      m_ilvl_p = m_ilvl;
      if (m_mhist[21:2] == {20{!m_mlvl}}) m_mlvl = !m_mlvl;
      if (m_ihist[21:2] == {20{!m_ilvl}}) m_ilvl = !m_ilvl;
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clkMSec);
      model_cycle();
      @(posedge clkMSec);
      cyc++;
      #1;
    end
  endtask

  task automatic mode_tap();
    modeBtn = 1'b1;
    step(30);
    modeBtn = 1'b0;
    step(50);
  endtask

  int w;

  initial begin
    step(3);
    reset = 1'b0;

    // RUN: three ticks, an ignored increment tap in RUN.
    w = cyc;
    step(100);
    incBtn = 1'b1;
    step(30);
    incBtn = 1'b0;
    step(2870);
    check("run_sec_count", count_from(sec_q, w), 3);
    check("run_sec_0", nth_from(sec_q, w, 0), 999);
    check("run_sec_1", nth_from(sec_q, w, 1), 1999);
    check("run_sec_2", nth_from(sec_q, w, 2), 2999);
    check("run_min_none", count_from(min_q, w), 0);
    check("run_hour_none", count_from(hour_q, w), 0);

    // Full cascade at a tick.
    w = cyc;
    secMax = 1'b1;
    minMax = 1'b1;
    step(1000);
    secMax = 1'b0;
    minMax = 1'b0;
    check("cascade_sec", nth_from(sec_q, w, 0), 999);
    check("cascade_min", nth_from(min_q, w, 0), 999);
    check("cascade_hour", nth_from(hour_q, w, 0), 999);
    check("cascade_hour_count", count_from(hour_q, w), 1);

    // Mode press: accepted 23 cycles after the raw edge, state shows next cycle.
    w = cyc;
    modeBtn = 1'b1;
    step(23);
    check("sethour_before_press", setHour, 1'b0);
    step(1);
    check("sethour_after_press", setHour, 1'b1);
    step(6);
    modeBtn = 1'b0;
    step(50);

    w = cyc;
    incBtn = 1'b1;
    step(30);
    incBtn = 1'b0;
    step(4970);
    check("sethour_inc_count", count_from(hour_q, w), 1);
    check("sethour_inc_at", nth_from(hour_q, w, 0), 23);
    check("sethour_no_sec", count_from(sec_q, w), 0);
    check("sethour_no_min", count_from(min_q, w), 0);

    // Glitchy increment never debounces.
    w = cyc;
    repeat (10) begin
      incBtn = 1'b1;
      step(10);
      incBtn = 1'b0;
      step(10);
    end
    step(40);
    check("glitch_no_hour", count_from(hour_q, w), 0);
    check("glitch_still_sethour", setHour, 1'b1);

    // SET_MIN auto-repeat while held for 1000 cycles.
    mode_tap();
    check("in_setmin", setMin, 1'b1);
    w = cyc;
    incBtn = 1'b1;
    step(1000);
    incBtn = 1'b0;
    step(100);
    check("repeat_count", count_from(min_q, w), 4);
    check("repeat_0", nth_from(min_q, w, 0), 23);
    check("repeat_1", nth_from(min_q, w, 1), 523);
    check("repeat_2", nth_from(min_q, w, 2), 723);
    check("repeat_3", nth_from(min_q, w, 3), 923);
    check("repeat_no_hour", count_from(hour_q, w), 0);

    // SET_MIN -> RUN: secClr on the press cycle, next tick 1000 cycles later.
    w = cyc;
    modeBtn = 1'b1;
    step(30);
    modeBtn = 1'b0;
    step(1070);
    check("secclr_count", count_from(clr_q, w), 1);
    check("secclr_at", nth_from(clr_q, w, 0), 23);
    check("after_clr_sec", nth_from(sec_q, w, 0), 1023);
    check("back_in_run", {setHour, setMin}, 2'b00);

    // Simultaneous mode and inc press in SET_HOUR: mode wins, inc dropped.
    mode_tap();
    w = cyc;
    modeBtn = 1'b1;
    incBtn  = 1'b1;
    step(30);
    modeBtn = 1'b0;
    incBtn  = 1'b0;
    step(50);
    check("simul_setmin", setMin, 1'b1);
    check("simul_no_hour", count_from(hour_q, w), 0);
    check("simul_no_min", count_from(min_q, w), 0);

    // Back to RUN, into SET_HOUR, then reset mid-set.
    mode_tap();
    mode_tap();
    check("pre_reset_sethour", setHour, 1'b1);
    w = cyc;
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check("reset_outputs_zero",
          {secInc, minInc, hourInc, secClr, setHour, setMin, blink}, 7'd0);
    step(1000);
    check("reset_no_secclr", count_from(clr_q, w), 0);
    check("reset_sec_count", count_from(sec_q, w), 1);
    check("reset_sec_at", nth_from(sec_q, w, 0), 1000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
